// File: rtl/ysyx_axi_mem_pkg.sv
// Shared constants, FSM state types and range helper for the AXI4 memory slave.
package ysyx_axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  // Unsigned offset compare also rejects addresses below base (they wrap high).
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return off < bytes;
  endfunction

endpackage

// File: rtl/ysyx_axi4_mem_slave_if.sv
// AXI4 slave-side bundle (AR/R/AW/W/B) for the memory slave.
interface ysyx_axi4_mem_slave_if;
  logic        io_slave_arvalid;
  logic        io_slave_arready;
  logic [31:0] io_slave_araddr;
  logic [3:0]  io_slave_arid;
  logic [7:0]  io_slave_arlen;
  logic [2:0]  io_slave_arsize;
  logic [1:0]  io_slave_arburst;

  logic        io_slave_rvalid;
  logic        io_slave_rready;
  logic [63:0] io_slave_rdata;
  logic [1:0]  io_slave_rresp;
  logic        io_slave_rlast;
  logic [3:0]  io_slave_rid;

  logic        io_slave_awvalid;
  logic        io_slave_awready;
  logic [31:0] io_slave_awaddr;
  logic [3:0]  io_slave_awid;
  logic [7:0]  io_slave_awlen;
  logic [2:0]  io_slave_awsize;
  logic [1:0]  io_slave_awburst;

  logic        io_slave_wvalid;
  logic        io_slave_wready;
  logic [63:0] io_slave_wdata;
  logic [7:0]  io_slave_wstrb;
  logic        io_slave_wlast;

  logic        io_slave_bvalid;
  logic        io_slave_bready;
  logic [1:0]  io_slave_bresp;
  logic [3:0]  io_slave_bid;

  modport master (
    output io_slave_arvalid, io_slave_araddr, io_slave_arid, io_slave_arlen,
           io_slave_arsize, io_slave_arburst, io_slave_rready,
           io_slave_awvalid, io_slave_awaddr, io_slave_awid, io_slave_awlen,
           io_slave_awsize, io_slave_awburst,
           io_slave_wvalid, io_slave_wdata, io_slave_wstrb, io_slave_wlast,
           io_slave_bready,
    input  io_slave_arready, io_slave_rvalid, io_slave_rdata, io_slave_rresp,
           io_slave_rlast, io_slave_rid, io_slave_awready, io_slave_wready,
           io_slave_bvalid, io_slave_bresp, io_slave_bid
  );

  modport slave (
    input  io_slave_arvalid, io_slave_araddr, io_slave_arid, io_slave_arlen,
           io_slave_arsize, io_slave_arburst, io_slave_rready,
           io_slave_awvalid, io_slave_awaddr, io_slave_awid, io_slave_awlen,
           io_slave_awsize, io_slave_awburst,
           io_slave_wvalid, io_slave_wdata, io_slave_wstrb, io_slave_wlast,
           io_slave_bready,
    output io_slave_arready, io_slave_rvalid, io_slave_rdata, io_slave_rresp,
           io_slave_rlast, io_slave_rid, io_slave_awready, io_slave_wready,
           io_slave_bvalid, io_slave_bresp, io_slave_bid
  );
endinterface

// File: rtl/ysyx_axi_burst_addr.sv
// Next beat address: FIXED holds, every other burst type steps by the beat size.
module ysyx_axi_burst_addr
  import ysyx_axi_mem_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_o
);

  assign next_o = (burst_i == BURST_FIXED) ? addr_i : addr_i + (32'd1 << size_i);

endmodule

// File: rtl/ysyx_axi4_mem_slave.sv
// AXI4 memory slave with independent read/write FSMs over a 64-bit word store.
// Define YSYX_AXI_MEM_RANGE_ERR_EN to answer SLVERR outside [BASE_ADDR, BASE_ADDR+8*MEM_WORDS).
//
// state   | meaning
// R_IDLE  | arready high, waiting for an AR handshake
// R_BURST | rvalid high, presenting the current read beat
// W_IDLE  | awready high, waiting for an AW handshake
// W_DATA  | wready high, accepting write beats until count == awlen
// W_RESP  | bvalid high, waiting for bready
module ysyx_axi4_mem_slave
  import ysyx_axi_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ysyx_axi4_mem_slave_if.slave bus
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) * 32'd8;

  logic [63:0] mem_q [MEM_WORDS];

  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d, r_addr_nxt, r_fetch_addr;
  logic [7:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_fetch_cnt, r_fetch_len;
  logic [2:0]  r_size_q, r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [3:0]  r_id_q, r_id_d;
  logic [63:0] rdata_q, rdata_d, r_mem_word;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic        r_ok;

  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d, w_addr_nxt;
  logic [7:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [3:0]  w_id_q, w_id_d;
  logic        w_err_q, w_err_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_ok, w_we;
  logic        unused_wlast;

  assign unused_wlast = bus.io_slave_wlast;

`ifdef YSYX_AXI_MEM_RANGE_ERR_EN
  assign r_ok = addr_in_range(r_fetch_addr, BASE_ADDR, MEM_BYTES);
  assign w_ok = addr_in_range(w_addr_q, BASE_ADDR, MEM_BYTES);
`else
  logic [63:0] unused_range_cfg;
  assign unused_range_cfg = {BASE_ADDR, MEM_BYTES};
  assign r_ok = 1'b1;
  assign w_ok = 1'b1;
`endif

  ysyx_axi_burst_addr u_r_addr (
    .addr_i  (r_addr_q),
    .size_i  (r_size_q),
    .burst_i (r_burst_q),
    .next_o  (r_addr_nxt)
  );

  ysyx_axi_burst_addr u_w_addr (
    .addr_i  (w_addr_q),
    .size_i  (w_size_q),
    .burst_i (w_burst_q),
    .next_o  (w_addr_nxt)
  );

  // The beat loaded next is either the AR address or the successor of the current beat.
  assign r_fetch_addr = (r_state_q == R_IDLE) ? bus.io_slave_araddr : r_addr_nxt;
  assign r_fetch_cnt  = (r_state_q == R_IDLE) ? 8'd0 : r_cnt_q + 8'd1;
  assign r_fetch_len  = (r_state_q == R_IDLE) ? bus.io_slave_arlen : r_len_q;
  assign r_mem_word   = mem_q[r_fetch_addr[IDX_W+2:3]];

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_id_d    = r_id_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.io_slave_arvalid) begin
          r_state_d = R_BURST;
          r_len_d   = bus.io_slave_arlen;
          r_size_d  = bus.io_slave_arsize;
          r_burst_d = bus.io_slave_arburst;
          r_id_d    = bus.io_slave_arid;
          r_addr_d  = r_fetch_addr;
          r_cnt_d   = r_fetch_cnt;
          rdata_d   = r_ok ? r_mem_word : 64'd0;
          rresp_d   = r_ok ? RESP_OKAY : RESP_SLVERR;
          rlast_d   = (r_fetch_cnt == r_fetch_len);
        end
      end
      R_BURST: begin
        if (bus.io_slave_rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            r_addr_d = r_fetch_addr;
            r_cnt_d  = r_fetch_cnt;
            rdata_d  = r_ok ? r_mem_word : 64'd0;
            rresp_d  = r_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_d  = (r_fetch_cnt == r_fetch_len);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_id_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_id_q    <= r_id_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (bus.io_slave_awvalid) begin
          w_state_d = W_DATA;
          w_addr_d  = bus.io_slave_awaddr;
          w_len_d   = bus.io_slave_awlen;
          w_size_d  = bus.io_slave_awsize;
          w_burst_d = bus.io_slave_awburst;
          w_id_d    = bus.io_slave_awid;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (bus.io_slave_wvalid) begin
          w_addr_d = w_addr_nxt;
          w_cnt_d  = w_cnt_q + 8'd1;
          w_err_d  = w_err_q | ~w_ok;
          // The burst length counter, not wlast, closes the burst.
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
            bresp_d   = (w_err_q | ~w_ok) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (bus.io_slave_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      bresp_q   <= bresp_d;
    end
  end

  assign w_we = (w_state_q == W_DATA) && bus.io_slave_wvalid && w_ok;

  // Store is deliberately left out of reset; a read in the same cycle sees the old word.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.io_slave_wstrb[b]) begin
          mem_q[w_addr_q[IDX_W+2:3]][8*b +: 8] <= bus.io_slave_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.io_slave_arready = (r_state_q == R_IDLE);
  assign bus.io_slave_rvalid  = (r_state_q == R_BURST);
  assign bus.io_slave_rdata   = rdata_q;
  assign bus.io_slave_rresp   = rresp_q;
  assign bus.io_slave_rlast   = rlast_q;
  assign bus.io_slave_rid     = r_id_q;

  assign bus.io_slave_awready = (w_state_q == W_IDLE);
  assign bus.io_slave_wready  = (w_state_q == W_DATA);
  assign bus.io_slave_bvalid  = (w_state_q == W_RESP);
  assign bus.io_slave_bresp   = bresp_q;
  assign bus.io_slave_bid     = w_id_q;

endmodule

// File: tb/tb_ysyx_axi4_mem_slave.sv
// Randomized bench for ysyx_axi4_mem_slave against a word-array reference model.
module tb_ysyx_axi4_mem_slave;

  localparam int          MW   = 1024;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_axi4_mem_slave_if bus ();

  ysyx_axi4_mem_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [63:0] ref_mem [MW];
  logic [63:0] wdat [256];
  logic [7:0]  wstb [256];
  logic [63:0] rd_got [$];
  logic [1:0]  last_rresp;
  logic [1:0]  last_bresp;
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
`ifdef YSYX_AXI_MEM_RANGE_ERR_EN
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(MW * 8)));
`else
    return (a == a);
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) & 32'(MW - 1));
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] size,
                                      input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bdelay);
    logic [31:0] a;
    logic err;
    int t;
    bus.io_slave_awvalid = 1'b1;
    bus.io_slave_awid    = id;
    bus.io_slave_awaddr  = addr;
    bus.io_slave_awlen   = len;
    bus.io_slave_awsize  = size;
    bus.io_slave_awburst = burst;
    t = 0;
    while (!bus.io_slave_awready && t < 50) begin tick(); t++; end
    check_eq("awready", 64'(bus.io_slave_awready), 64'd1);
    tick();
    bus.io_slave_awvalid = 1'b0;
    a = addr;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.io_slave_wvalid = 1'b0;
        tick();
      end
      bus.io_slave_wvalid = 1'b1;
      bus.io_slave_wdata  = wdat[i];
      bus.io_slave_wstrb  = wstb[i];
      bus.io_slave_wlast  = (i == int'(len));
      t = 0;
      while (!bus.io_slave_wready && t < 50) begin tick(); t++; end
      check_eq("wready", 64'(bus.io_slave_wready), 64'd1);
      tick();
      if (in_rng(a)) begin
        for (int b = 0; b < 8; b++)
          if (wstb[i][b]) ref_mem[widx(a)][8*b +: 8] = wdat[i][8*b +: 8];
      end else begin
        err = 1'b1;
      end
      a = nxt(a, size, burst);
    end
    bus.io_slave_wvalid = 1'b0;
    bus.io_slave_wlast  = 1'b0;
    for (int k = 0; k < bdelay; k++) begin
      check_eq("bvalid_hold", 64'(bus.io_slave_bvalid), 64'd1);
      check_eq("bid_hold", 64'(bus.io_slave_bid), 64'(id));
      tick();
    end
    bus.io_slave_bready = 1'b1;
    t = 0;
    while (!bus.io_slave_bvalid && t < 50) begin tick(); t++; end
    check_eq("bvalid", 64'(bus.io_slave_bvalid), 64'd1);
    check_eq("bid", 64'(bus.io_slave_bid), 64'(id));
    check_eq("bresp", 64'(bus.io_slave_bresp), err ? 64'd2 : 64'd0);
    last_bresp = bus.io_slave_bresp;
    tick();
    bus.io_slave_bready = 1'b0;
    check_eq("bvalid_drop", 64'(bus.io_slave_bvalid), 64'd0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_cyc);
    logic [31:0] a;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    int t;
    bus.io_slave_arvalid = 1'b1;
    bus.io_slave_arid    = id;
    bus.io_slave_araddr  = addr;
    bus.io_slave_arlen   = len;
    bus.io_slave_arsize  = size;
    bus.io_slave_arburst = burst;
    t = 0;
    while (!bus.io_slave_arready && t < 50) begin tick(); t++; end
    check_eq("arready", 64'(bus.io_slave_arready), 64'd1);
    tick();
    bus.io_slave_arvalid = 1'b0;
    check_eq("r_latency", 64'(bus.io_slave_rvalid), 64'd1);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_d = in_rng(a) ? ref_mem[widx(a)] : 64'd0;
      exp_r = in_rng(a) ? 2'b00 : 2'b10;
      if (i == stall_beat) begin
        for (int k = 0; k < stall_cyc; k++) begin
          bus.io_slave_rready = 1'b0;
          check_eq("stall_rvalid", 64'(bus.io_slave_rvalid), 64'd1);
          check_eq("stall_rdata", bus.io_slave_rdata, exp_d);
          check_eq("stall_rlast", 64'(bus.io_slave_rlast), 64'(i == int'(len)));
          check_eq("stall_rid", 64'(bus.io_slave_rid), 64'(id));
          tick();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.io_slave_rready = 1'b0;
        tick();
      end
      bus.io_slave_rready = 1'b1;
      t = 0;
      while (!bus.io_slave_rvalid && t < 50) begin tick(); t++; end
      check_eq("rvalid", 64'(bus.io_slave_rvalid), 64'd1);
      check_eq("rdata", bus.io_slave_rdata, exp_d);
      check_eq("rresp", 64'(bus.io_slave_rresp), 64'(exp_r));
      check_eq("rlast", 64'(bus.io_slave_rlast), 64'(i == int'(len)));
      check_eq("rid", 64'(bus.io_slave_rid), 64'(id));
      rd_got.push_back(bus.io_slave_rdata);
      last_rresp = bus.io_slave_rresp;
      tick();
      a = nxt(a, size, burst);
    end
    bus.io_slave_rready = 1'b0;
    check_eq("r_done_rvalid", 64'(bus.io_slave_rvalid), 64'd0);
    check_eq("r_done_arready", 64'(bus.io_slave_arready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, ca;
    logic [63:0] old_w, alias_w;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  len;

    bus.io_slave_arvalid = 0; bus.io_slave_araddr = 0; bus.io_slave_arid = 0;
    bus.io_slave_arlen = 0; bus.io_slave_arsize = 0; bus.io_slave_arburst = 0;
    bus.io_slave_rready = 0;
    bus.io_slave_awvalid = 0; bus.io_slave_awaddr = 0; bus.io_slave_awid = 0;
    bus.io_slave_awlen = 0; bus.io_slave_awsize = 0; bus.io_slave_awburst = 0;
    bus.io_slave_wvalid = 0; bus.io_slave_wdata = 0; bus.io_slave_wstrb = 0;
    bus.io_slave_wlast = 0; bus.io_slave_bready = 0;

    repeat (3) tick();
    check_eq("rst_rvalid",  64'(bus.io_slave_rvalid), 64'd0);
    check_eq("rst_bvalid",  64'(bus.io_slave_bvalid), 64'd0);
    check_eq("rst_wready",  64'(bus.io_slave_wready), 64'd0);
    check_eq("rst_rlast",   64'(bus.io_slave_rlast), 64'd0);
    check_eq("rst_rdata",   bus.io_slave_rdata, 64'd0);
    check_eq("rst_rresp",   64'(bus.io_slave_rresp), 64'd0);
    check_eq("rst_rid",     64'(bus.io_slave_rid), 64'd0);
    check_eq("rst_bresp",   64'(bus.io_slave_bresp), 64'd0);
    check_eq("rst_bid",     64'(bus.io_slave_bid), 64'd0);
    check_eq("rst_arready", 64'(bus.io_slave_arready), 64'd1);
    check_eq("rst_awready", 64'(bus.io_slave_awready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Fill the whole store so every later read has a known expectation.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        wdat[i] = {$urandom, $urandom};
        wstb[i] = 8'hFF;
      end
      axi_write(4'(k), BASE + 32'(k * 2048), 8'd255, 3'd3, 2'b01, 0);
    end

    // Single-beat write/read with distinct ids.
    wdat[0] = 64'h1122_3344_5566_7788; wstb[0] = 8'hFF;
    axi_write(4'h5, BASE, 8'd0, 3'd3, 2'b01, 0);
    rd_got.delete();
    axi_read(4'h9, BASE, 8'd0, 3'd3, 2'b01, -1, 0);
    check_eq("single_data", rd_got[0], 64'h1122_3344_5566_7788);

    // Four-beat INCR.
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
    axi_write(4'h2, BASE + 32'h10, 8'd3, 3'd3, 2'b01, 0);
    rd_got.delete();
    axi_read(4'h3, BASE + 32'h10, 8'd3, 3'd3, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) check_eq("incr_beat", rd_got[i], 64'(i + 1));

    // Partial strobe over a zero word.
    wdat[0] = 64'd0; wstb[0] = 8'hFF;
    axi_write(4'h1, BASE + 32'h80, 8'd0, 3'd3, 2'b01, 0);
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'h0F;
    axi_write(4'h1, BASE + 32'h80, 8'd0, 3'd3, 2'b01, 0);
    rd_got.delete();
    axi_read(4'h1, BASE + 32'h80, 8'd0, 3'd3, 2'b01, -1, 0);
    check_eq("strb_rb", rd_got[0], 64'h0000_0000_FFFF_FFFF);

    // Backpressure on R and B.
    axi_read(4'h6, BASE + 32'h10, 8'd3, 3'd3, 2'b01, 1, 5);
    for (int i = 0; i < 3; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
    axi_write(4'h7, BASE + 32'h200, 8'd2, 3'd3, 2'b01, 3);

    // Edge below the base: SLVERR with the range check, aliasing to the top word without.
    alias_w = ref_mem[MW - 1];
    wdat[0] = 64'hDEAD_BEEF_DEAD_BEEF; wstb[0] = 8'hFF;
    axi_write(4'h8, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 0);
    rd_got.delete();
    axi_read(4'h8, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, -1, 0);
`ifdef YSYX_AXI_MEM_RANGE_ERR_EN
    check_eq("oor_bresp", 64'(last_bresp), 64'd2);
    check_eq("oor_rresp", 64'(last_rresp), 64'd2);
    check_eq("oor_rdata", rd_got[0], 64'd0);
    rd_got.delete();
    axi_read(4'h8, BASE + 32'(8 * (MW - 1)), 8'd0, 3'd3, 2'b01, -1, 0);
    check_eq("oor_unchanged", rd_got[0], alias_w);
`else
    check_eq("alias_rdata", rd_got[0], 64'hDEAD_BEEF_DEAD_BEEF);
`endif

    // Same-cycle write and read of one word: read returns the old value.
    ca = BASE + 32'h40;
    old_w = ref_mem[widx(ca)];
    bus.io_slave_awvalid = 1'b1; bus.io_slave_awaddr = ca; bus.io_slave_awid = 4'h3;
    bus.io_slave_awlen = 8'd0; bus.io_slave_awsize = 3'd3; bus.io_slave_awburst = 2'b01;
    check_eq("cc_awready", 64'(bus.io_slave_awready), 64'd1);
    tick();
    bus.io_slave_awvalid = 1'b0;
    bus.io_slave_wvalid = 1'b1; bus.io_slave_wdata = ~old_w; bus.io_slave_wstrb = 8'hFF;
    bus.io_slave_wlast = 1'b1;
    bus.io_slave_arvalid = 1'b1; bus.io_slave_araddr = ca; bus.io_slave_arid = 4'h4;
    bus.io_slave_arlen = 8'd0; bus.io_slave_arsize = 3'd3; bus.io_slave_arburst = 2'b01;
    check_eq("cc_wready", 64'(bus.io_slave_wready), 64'd1);
    check_eq("cc_arready", 64'(bus.io_slave_arready), 64'd1);
    tick();
    bus.io_slave_wvalid = 1'b0; bus.io_slave_wlast = 1'b0; bus.io_slave_arvalid = 1'b0;
    ref_mem[widx(ca)] = ~old_w;
    check_eq("cc_rvalid", 64'(bus.io_slave_rvalid), 64'd1);
    check_eq("cc_rdata_old", bus.io_slave_rdata, old_w);
    check_eq("cc_bvalid", 64'(bus.io_slave_bvalid), 64'd1);
    bus.io_slave_rready = 1'b1; bus.io_slave_bready = 1'b1;
    tick();
    bus.io_slave_rready = 1'b0; bus.io_slave_bready = 1'b0;
    rd_got.delete();
    axi_read(4'h4, ca, 8'd0, 3'd3, 2'b01, -1, 0);
    check_eq("cc_rdata_new", rd_got[0], ~old_w);

    // Reset in the middle of an 8-beat read.
    addr = BASE + 32'h100;
    bus.io_slave_arvalid = 1'b1; bus.io_slave_araddr = addr; bus.io_slave_arid = 4'hA;
    bus.io_slave_arlen = 8'd7; bus.io_slave_arsize = 3'd3; bus.io_slave_arburst = 2'b01;
    check_eq("rst_mid_arready", 64'(bus.io_slave_arready), 64'd1);
    tick();
    bus.io_slave_arvalid = 1'b0;
    bus.io_slave_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_mid_beat", bus.io_slave_rdata, ref_mem[widx(addr + 32'(8 * i))]);
      tick();
    end
    check_eq("rst_mid_beat3", bus.io_slave_rdata, ref_mem[widx(addr + 32'd24)]);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_rvalid", 64'(bus.io_slave_rvalid), 64'd0);
    check_eq("rst_mid_arready2", 64'(bus.io_slave_arready), 64'd1);
    check_eq("rst_mid_rlast", 64'(bus.io_slave_rlast), 64'd0);
    bus.io_slave_rready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_mid_no_resp", 64'(bus.io_slave_rvalid), 64'd0);
    axi_read(4'hB, addr, 8'd7, 3'd3, 2'b01, -1, 0);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 3));
      len   = 8'($urandom_range(0, 15));
      addr  = BASE + (32'($urandom_range(0, MW * 8 - 1)) & ~((32'd1 << size) - 32'd1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin
          wdat[i] = {$urandom, $urandom};
          wstb[i] = 8'($urandom_range(0, 255));
        end
        axi_write(4'($urandom_range(0, 15)), addr, len, size, burst, $urandom_range(0, 2));
      end else begin
        axi_read(4'($urandom_range(0, 15)), addr, len, size, burst,
                 $urandom_range(0, 15), $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
